// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, FSM state encoding and step-counter
// sizing for the alu_seq block and its iterative multiply/divide engine.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } alu_state_e;

  // Step counter must hold the value WIDTH itself (it counts WIDTH..1).
  function automatic int step_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative unsigned magnitude engine. Multiply is a
// shift-add over WIDTH steps; divide (only with ALU_SEQ_DIV_EN defined) is a
// restoring divider over WIDTH steps. Both share one 2*WIDTH accumulator:
// for multiply it ends as the full product, for divide the low half ends as
// the quotient and the high half as the remainder.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
`ifdef ALU_SEQ_DIV_EN
  input  logic               is_div,
`endif
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               done
);

  localparam int CNT_W = step_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  logic [WIDTH-1:0]   b_reg;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
`ifdef ALU_SEQ_DIV_EN
  logic               div_mode;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
`endif

  // Done strobes during the final step so the caller can leave its busy state on that edge.
  assign done = busy && (cnt == CNT_ONE);

  // One iteration step of whichever operation is running.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, b_reg};
    div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step_next = div_mode ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
  end

  // Load operands on start, then step once per cycle for WIDTH cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      b_reg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start) begin
      acc   <= {{WIDTH{1'b0}}, mag_a};
      b_reg <= mag_b;
      cnt   <= CNT_LOAD;
      busy  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      div_mode <= is_div;
`endif
    end else if (busy) begin
      acc <= step_next;
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready issue handshake. Single-cycle
// add/sub/and/or/sll/sra, iterative signed multiply, and iterative signed
// divide when ALU_SEQ_DIV_EN is defined (otherwise opcode 7 is unsupported).
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here, mul/div start here
// MUL   | engine running WIDTH shift-add steps
// DIV   | engine running WIDTH restoring-divide steps
// FIX   | apply result sign, register result and flags
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       opcode,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             is_not_equal,
  output logic             is_less_than,
  output logic             overflow,
  output logic             exception
);

  alu_state_e         state;
  logic               accept;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               add_ovf;
  logic               sub_ovf;
  logic               cmp_ne;
  logic               cmp_lt;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_ovf;
  logic               sc_exc;
  logic               iter_start;
  logic               eng_start;
  logic [2*WIDTH-1:0] eng_acc;
  logic               eng_done;
  logic               res_neg;
  logic               pend_ne;
  logic               pend_lt;
  logic [2*WIDTH-1:0] mul_signed;
  logic               mul_ovf;
`ifdef ALU_SEQ_DIV_EN
  logic               iter_div;
  logic               pend_div;
  logic [WIDTH-1:0]   div_signed;
  logic               div_ovf;
`endif

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  assign sum     = operand_a + operand_b;
  assign diff    = operand_a - operand_b;
  assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
  assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);
  assign cmp_ne  = (operand_a != operand_b);
  assign cmp_lt  = diff[WIDTH-1] ^ sub_ovf;
  // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
  assign abs_a   = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b   = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // Single-cycle result selection and decision whether to launch the engine.
  always_comb begin
    sc_result  = '0;
    sc_ovf     = 1'b0;
    sc_exc     = 1'b0;
    iter_start = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    iter_div   = 1'b0;
`endif
    case (opcode)
      OP_ADD: begin sc_result = sum;  sc_ovf = add_ovf; end
      OP_SUB: begin sc_result = diff; sc_ovf = sub_ovf; end
      OP_AND: sc_result = operand_a & operand_b;
      OP_OR:  sc_result = operand_a | operand_b;
      OP_SLL: sc_result = operand_a << shamt;
      OP_SRA: sc_result = $signed(operand_a) >>> shamt;
      OP_MUL: iter_start = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        // Divide by zero completes immediately without touching the engine.
        if (operand_b == '0) begin
          sc_exc = 1'b1;
        end else begin
          iter_start = 1'b1;
          iter_div   = 1'b1;
        end
      end
`endif
      default: sc_exc = 1'b1;
    endcase
  end

  assign eng_start = accept && iter_start;

  // Sign fix-up of the engine's magnitude results.
  assign mul_signed = res_neg ? -eng_acc : eng_acc;
  assign mul_ovf    = !((&mul_signed[2*WIDTH-1:WIDTH-1]) || !(|mul_signed[2*WIDTH-1:WIDTH-1]));
`ifdef ALU_SEQ_DIV_EN
  assign div_signed = res_neg ? -eng_acc[WIDTH-1:0] : eng_acc[WIDTH-1:0];
  // A positive quotient with the MSB set only arises from MIN / -1.
  assign div_ovf    = !res_neg && eng_acc[WIDTH-1];
`endif

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_engine (
    .clock (clock),
    .reset (reset),
    .start (eng_start),
`ifdef ALU_SEQ_DIV_EN
    .is_div(iter_div),
`endif
    .mag_a (abs_a),
    .mag_b (abs_b),
    .acc   (eng_acc),
    .done  (eng_done)
  );

  // Control FSM and output registers; outputs hold between out_valid pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      result       <= '0;
      is_not_equal <= 1'b0;
      is_less_than <= 1'b0;
      overflow     <= 1'b0;
      exception    <= 1'b0;
      res_neg      <= 1'b0;
      pend_ne      <= 1'b0;
      pend_lt      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      pend_div     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (iter_start) begin
`ifdef ALU_SEQ_DIV_EN
              state    <= iter_div ? DIV : MUL;
              pend_div <= iter_div;
`else
              state    <= MUL;
`endif
              res_neg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
              pend_ne <= cmp_ne;
              pend_lt <= cmp_lt;
            end else begin
              out_valid    <= 1'b1;
              result       <= sc_result;
              overflow     <= sc_ovf;
              exception    <= sc_exc;
              is_not_equal <= cmp_ne;
              is_less_than <= cmp_lt;
            end
          end
        end
        MUL, DIV: begin
          if (eng_done) state <= FIX;
        end
        FIX: begin
          state        <= IDLE;
          out_valid    <= 1'b1;
          exception    <= 1'b0;
          is_not_equal <= pend_ne;
          is_less_than <= pend_lt;
`ifdef ALU_SEQ_DIV_EN
          if (pend_div) begin
            result   <= div_signed;
            overflow <= div_ovf;
          end else begin
            result   <= mul_signed[WIDTH-1:0];
            overflow <= mul_ovf;
          end
`else
          result   <= mul_signed[WIDTH-1:0];
          overflow <= mul_ovf;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32). Honours ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [4:0]   opcode = '0;
  logic [4:0]   shamt = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         is_not_equal;
  logic         is_less_than;
  logic         overflow;
  logic         exception;

  typedef struct {
    logic [31:0] r;
    logic        ne;
    logic        lt;
    logic        ovf;
    logic        exc;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy_until = 0;
  logic [35:0] last = '0;

  alu_seq #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .opcode      (opcode),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .result      (result),
    .is_not_equal(is_not_equal),
    .is_less_than(is_less_than),
    .overflow    (overflow),
    .exception   (exception)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: signed 64-bit arithmetic straight from the operation definitions.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb_v, wide, maxv, minv;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    maxv = 64'sd2147483647;
    minv = -maxv - 1;
    e.r = '0; e.ovf = 1'b0; e.exc = 1'b0; e.lat = 1; e.acc_edge = 0;
    e.ne = (a != b);
    e.lt = (sa < sb_v);
    case (op)
      5'd0: begin wide = sa + sb_v; e.r = wide[31:0]; e.ovf = (wide > maxv) || (wide < minv); end
      5'd1: begin wide = sa - sb_v; e.r = wide[31:0]; e.ovf = (wide > maxv) || (wide < minv); end
      5'd2: e.r = a & b;
      5'd3: e.r = a | b;
      5'd4: e.r = a << sh;
      5'd5: begin wide = sa >>> sh; e.r = wide[31:0]; end
      5'd6: begin
        wide  = sa * sb_v;
        e.r   = wide[31:0];
        e.ovf = (wide != longint'($signed(e.r)));
        e.lat = W + 2;
      end
      5'd7: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 32'd0) begin
          e.exc = 1'b1;
        end else begin
          wide  = sa / sb_v;
          e.r   = wide[31:0];
          e.ovf = (wide > maxv);
          e.lat = W + 2;
        end
`else
        e.exc = 1'b1;
`endif
      end
      default: e.exc = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15)) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  // Wait (driving ignored junk) until the model says the DUT is ready, then issue one op.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic [4:0] sh, input bit fixed, input logic [31:0] fr,
                          input logic fovf, input logic fexc);
    exp_t e;
    while (cyc < busy_until) begin
      check("in_ready_busy", 64'(in_ready), 64'(0));
      in_valid  = 1'($urandom_range(0, 1));
      operand_a = $urandom;
      operand_b = $urandom;
      opcode    = 5'($urandom);
      shamt     = 5'($urandom);
      @(negedge clock);
    end
    check("in_ready_idle", 64'(in_ready), 64'(1));
    e = model(a, b, op, sh);
    if (fixed) begin
      e.r   = fr;
      e.ovf = fovf;
      e.exc = fexc;
    end
    e.acc_edge = cyc + 1;
    sb.push_back(e);
    busy_until = cyc + 1 + ((e.lat > 1) ? (W + 1) : 0);
    in_valid  = 1'b1;
    operand_a = a;
    operand_b = b;
    opcode    = op;
    shamt     = sh;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Monitor: pop and compare on every out_valid, otherwise check that outputs hold.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      last = '0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.r));
        check("ne_lt_ovf_exc", 64'({is_not_equal, is_less_than, overflow, exception}),
              64'({e.ne, e.lt, e.ovf, e.exc}));
        check("latency", 64'(cyc - e.acc_edge + 1), 64'(e.lat));
      end
      last = {result, is_not_equal, is_less_than, overflow, exception};
    end else begin
      check("hold", 64'({result, is_not_equal, is_less_than, overflow, exception}), 64'(last));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    check("reset_outputs", 64'({out_valid, result, is_not_equal, is_less_than, overflow, exception}), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    busy_until = cyc;

    // Directed cases with hand-computed expectations.
    drive_op(32'h7FFF_FFFF, 32'h1, 5'd0, 5'd0, 1, 32'h8000_0000, 1'b1, 1'b0);
    drive_op(32'd3, 32'd5, 5'd1, 5'd0, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drive_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2, 5'd0, 1, 32'h00F0_00F0, 1'b0, 1'b0);
    drive_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, 5'd0, 1, 32'hFFF0_FFF0, 1'b0, 1'b0);
    drive_op(32'h8000_0000, 32'h0, 5'd5, 5'd4, 1, 32'hF800_0000, 1'b0, 1'b0);
    drive_op(32'h1, 32'h0, 5'd4, 5'd31, 1, 32'h8000_0000, 1'b0, 1'b0);
    drive_op(32'h8000_0000, 32'h1, 5'd1, 5'd0, 1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    drive_op(32'hFFFF_FFF9, 32'd6, 5'd6, 5'd0, 1, 32'hFFFF_FFD6, 1'b0, 1'b0);
    drive_op(32'h0001_0000, 32'h0001_0000, 5'd6, 5'd0, 1, 32'h0, 1'b1, 1'b0);
    drive_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 5'd0, 1, 32'h8000_0000, 1'b1, 1'b0);
`ifdef ALU_SEQ_DIV_EN
    drive_op(32'hFFFF_FFF9, 32'd2, 5'd7, 5'd0, 1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    drive_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 5'd0, 1, 32'h8000_0000, 1'b1, 1'b0);
`else
    drive_op(32'hFFFF_FFF9, 32'd2, 5'd7, 5'd0, 1, 32'h0, 1'b0, 1'b1);
    drive_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 5'd0, 1, 32'h0, 1'b0, 1'b1);
`endif
    drive_op(32'd5, 32'd0, 5'd7, 5'd0, 1, 32'h0, 1'b0, 1'b1);
    drive_op(32'd12, 32'd34, 5'd9, 5'd0, 1, 32'h0, 1'b0, 1'b1);

    // Reset in the tenth cycle of a multiply: aborts silently.
    drive_op(32'd5, 32'd6, 5'd0, 5'd0, 1, 32'd11, 1'b0, 1'b0);
    drive_op(32'hFFFF_FFF9, 32'd6, 5'd6, 5'd0, 0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      check("in_ready_mul", 64'(in_ready), 64'(0));
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    check("abort_outputs", 64'({out_valid, result, is_not_equal, is_less_than, overflow, exception}), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clock);
    #2 reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("in_ready_after_reset", 64'(in_ready), 64'(1));
    end
    busy_until = cyc;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      drive_op(pick(), pick(), op, 5'($urandom), 0, 32'h0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
    check("drain", 64'(sb.size()), 64'(0));
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
